sym_align_deser: RTL

//  Serial-to-10b front end feeding the 8b10b symbol decoder. Shifts in one line bit
//  per strobe, hunts for the comma, and verifies symbol framing by per-half popcount

---
 rtl/enc8b10b_pkg.sv | 35 +++
 rtl/bsg_popcount.sv | 25 ++
 rtl/sym_legal_check.sv | 31 +++
 rtl/sym_align_deser.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/enc8b10b_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : enc8b10b_pkg
//  Description : Shared 8b10b definitions: comma pattern, aligner state
//                encoding and the table of legal popcount splits.
//  Revision    : 1.0  initial release
// ============================================================================
package enc8b10b_pkg;

  // K28.5-style comma as seen first-bit-first (upper pop 3, lower pop 2)
  localparam logic [9:0] ENC_COMMA = 10'b11100_00011;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  // Legal {pop(upper 5), pop(lower 5)} splits, one octal digit per half
  localparam int unsigned ENC_NUM_SPLITS = 5;
  localparam logic [ENC_NUM_SPLITS-1:0][5:0] ENC_LEGAL_SPLITS =
    {6'o32, 6'o23, 6'o41, 6'o14, 6'o33};

  function automatic logic enc_split_legal(input logic [2:0] pop_hi,
                                           input logic [2:0] pop_lo);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < ENC_NUM_SPLITS; k++) begin
      if (ENC_LEGAL_SPLITS[k] == {pop_hi, pop_lo}) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_popcount
//  Description : Combinational count of set bits in a WIDTH_P-bit vector.
//  Revision    : 1.0  initial release
// ============================================================================
module bsg_popcount #(
  parameter int WIDTH_P = 5
) (
  input  logic [WIDTH_P-1:0]              in_i,
  output logic [$clog2(WIDTH_P+1)-1:0]    cnt_o
);

  localparam int CNT_W = $clog2(WIDTH_P + 1);

  // Sum the bits one at a time; small widths only
  always_comb begin
    cnt_o = '0;
    for (int k = 0; k < WIDTH_P; k++) begin
      cnt_o = cnt_o + CNT_W'(in_i[k]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sym_legal_check.sv
`default_nettype none
// ============================================================================
//  Module      : sym_legal_check
//  Description : Flags whether a 10-bit symbol has a legal upper/lower
//                popcount split. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module sym_legal_check
  import enc8b10b_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       legal_o
);

  logic [2:0] pop_hi;
  logic [2:0] pop_lo;

  bsg_popcount #(.WIDTH_P(5)) u_pop_hi (
    .in_i  (sym_i[9:5]),
    .cnt_o (pop_hi)
  );

  bsg_popcount #(.WIDTH_P(5)) u_pop_lo (
    .in_i  (sym_i[4:0]),
    .cnt_o (pop_lo)
  );

  assign legal_o = enc_split_legal(pop_hi, pop_lo);

endmodule
`default_nettype wire

// File: rtl/sym_align_deser.sv
`default_nettype none
// ============================================================================
//  Module      : sym_align_deser
//  Description : Serial-to-10b front end. Hunts for the comma, confirms
//                framing with consecutive legal symbols, then emits aligned
//                10-bit symbols with a one-cycle valid pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module sym_align_deser
  import enc8b10b_pkg::*;
#(
  parameter logic [9:0] COMMA_P      = ENC_COMMA,
  parameter int         GOOD_SYMS_P  = 4,
  parameter int         ERR_THRESH_P = 3
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       bit_i,
  input  logic       bit_v_i,
  output logic [9:0] sym_o,
  output logic       sym_v_o,
  output logic       sym_err_o,
  output logic       locked_o,
  output logic       lock_lost_o
);

  localparam int GW = $clog2(GOOD_SYMS_P + 1);
  localparam int EW = $clog2(ERR_THRESH_P + 1);
  localparam logic [GW-1:0] GOOD_MAX  = GW'(GOOD_SYMS_P);
  localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_SYMS_P - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(ERR_THRESH_P - 1);

  align_state_e  state_q, state_d;
  logic [9:0]    sr_q, sr_d;
  logic [3:0]    phase_q, phase_d;
  logic [GW-1:0] good_q, good_d;
  logic [EW-1:0] err_q, err_d;
  logic [9:0]    sym_q, sym_d;
  logic          sym_v_q, sym_v_d;
  logic          sym_err_q, sym_err_d;
  logic          lost_q, lost_d;

  logic [9:0]    sr_nx;
  logic [3:0]    phase_inc;
  logic          boundary;
  logic          is_comma;
  logic          sym_legal;

  assign sr_nx     = {sr_q[8:0], bit_i};
  assign phase_inc = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
  assign boundary  = (phase_inc == 4'd9);
  assign is_comma  = (sr_nx == COMMA_P);

  sym_legal_check u_legal (
    .sym_i   (sr_nx),
    .legal_o (sym_legal)
  );

  // State and datapath registers; reset asserts asynchronously
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_HUNT;
      sr_q      <= '0;
      phase_q   <= '0;
      good_q    <= '0;
      err_q     <= '0;
      sym_q     <= '0;
      sym_v_q   <= 1'b0;
      sym_err_q <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      phase_q   <= phase_d;
      good_q    <= good_d;
      err_q     <= err_d;
      sym_q     <= sym_d;
      sym_v_q   <= sym_v_d;
      sym_err_q <= sym_err_d;
      lost_q    <= lost_d;
    end
  end

  // Next-state: comma hunt, framing check, locked symbol emission
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    phase_d   = phase_q;
    good_d    = good_q;
    err_d     = err_q;
    sym_d     = sym_q;
    sym_v_d   = 1'b0;
    sym_err_d = 1'b0;
    lost_d    = 1'b0;

    if (bit_v_i) begin
      sr_d    = sr_nx;
      phase_d = phase_inc;
    end

    case (state_q)
      ST_HUNT: begin
        if (bit_v_i && is_comma) begin
          state_d = ST_CHECK;
          phase_d = 4'd9;
          good_d  = GW'(1);
        end
      end
      ST_CHECK: begin
        if (bit_v_i) begin
          if (boundary) begin
            if (sym_legal) begin
              if (good_q >= GOOD_LAST) begin
                state_d = ST_LOCKED;
                good_d  = GOOD_MAX;
                err_d   = '0;
              end else begin
                good_d = good_q + GW'(1);
              end
            end else begin
              state_d = ST_HUNT;
              good_d  = '0;
            end
          end else if (is_comma) begin
            // Comma at a different phase: restart framing there
            phase_d = 4'd9;
            good_d  = GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (bit_v_i && boundary) begin
          sym_d     = sr_nx;
          sym_v_d   = 1'b1;
          sym_err_d = ~sym_legal;
          if (sym_legal) begin
            err_d = '0;
          end else if (err_q >= ERR_LAST) begin
            state_d = ST_HUNT;
            lost_d  = 1'b1;
            err_d   = '0;
            good_d  = '0;
          end else begin
            err_d = err_q + EW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  assign sym_o       = sym_q;
  assign sym_v_o     = sym_v_q;
  assign sym_err_o   = sym_err_q;
  assign lock_lost_o = lost_q;
  assign locked_o    = (state_q == ST_LOCKED);

endmodule
`default_nettype wire
